// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: machine width, PC step, fetch FSM states and
// the IF/ID register layout used by both fetch and decode.
package pipe_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP  = 32'd4;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  typedef enum logic [0:0] {
    RUN = 1'b0,
    BUF = 1'b1
  } if_state_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } if_id_t;

endpackage

// File: rtl/if_skid_buf.sv
// Single-entry skid register: catches the memory response that arrives while
// decode is stalled, and releases it when the stall drops.
module if_skid_buf
  import pipe_pkg::*;
#(
  parameter int XLEN = pipe_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            drain,
  input  logic            flush,
  input  logic [XLEN-1:0] load_pc,
  input  logic [XLEN-1:0] load_instr,
  output logic            buf_valid,
  output logic [XLEN-1:0] buf_pc,
  output logic [XLEN-1:0] buf_instr
);

  logic            valid_r;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] instr_r;

  // Entry register; flush beats load so a redirect never leaves a stale word.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      pc_r    <= {XLEN{1'b0}};
      instr_r <= {XLEN{1'b0}};
    end else if (flush) begin
      valid_r <= 1'b0;
    end else if (load) begin
      valid_r <= 1'b1;
      pc_r    <= load_pc;
      instr_r <= load_instr;
    end else if (drain) begin
      valid_r <= 1'b0;
    end
  end

  assign buf_valid = valid_r;
  assign buf_pc    = pc_r;
  assign buf_instr = instr_r;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the fetch PC, drives the 1-cycle instruction memory
// and fills the IF/ID register, absorbing stalls and redirects losslessly.
module if_fetch_stage
  import pipe_pkg::*;
#(
  parameter int              XLEN     = pipe_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = pipe_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instr
);

  if_state_t       state_r;
  if_state_t       state_nxt_s;
  logic [XLEN-1:0] fetch_pc_r;
  logic            inflight_r;
  logic [XLEN-1:0] inflight_pc_r;
  if_id_t          id_r;
  if_id_t          id_nxt_s;
  logic            req_s;
  logic            buf_load_s;
  logic            buf_drain_s;
  logic            buf_valid_s;
  logic [XLEN-1:0] buf_pc_s;
  logic [XLEN-1:0] buf_instr_s;

  // A request goes out whenever decode can accept next cycle; leaving BUF
  // qualifies too because the drained entry frees the only pending slot.
  assign req_s = ~rst & ~stall & ~redirect;

  // Next-state, skid control and IF/ID next value.
  always_comb begin
    state_nxt_s = state_r;
    buf_load_s  = 1'b0;
    buf_drain_s = 1'b0;
    id_nxt_s    = id_r;
    if (redirect) begin
      state_nxt_s    = RUN;
      id_nxt_s.valid = 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          if (stall) begin
            if (inflight_r) begin
              buf_load_s  = 1'b1;
              state_nxt_s = BUF;
            end else begin
              state_nxt_s = RUN;
            end
          end else if (inflight_r) begin
            id_nxt_s = '{valid: 1'b1, pc: inflight_pc_r, instr: imem_rdata};
          end else begin
            id_nxt_s.valid = 1'b0;
          end
        end
        BUF: begin
          if (stall) begin
            state_nxt_s = BUF;
          end else begin
            id_nxt_s    = '{valid: buf_valid_s, pc: buf_pc_s, instr: buf_instr_s};
            buf_drain_s = 1'b1;
            state_nxt_s = RUN;
          end
        end
        default: begin
          state_nxt_s = RUN;
        end
      endcase
    end
  end

  // FSM state and IF/ID register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= RUN;
      id_r    <= '{valid: 1'b0, pc: {XLEN{1'b0}}, instr: {XLEN{1'b0}}};
    end else begin
      state_r <= state_nxt_s;
      id_r    <= id_nxt_s;
    end
  end

  // Fetch PC and the one outstanding memory response.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_r    <= RESET_PC;
      inflight_r    <= 1'b0;
      inflight_pc_r <= {XLEN{1'b0}};
    end else begin
      inflight_r <= req_s;
      if (redirect) begin
        fetch_pc_r <= {redirect_pc[XLEN-1:2], 2'b00};
      end else if (req_s) begin
        fetch_pc_r    <= fetch_pc_r + PC_STEP;
        inflight_pc_r <= fetch_pc_r;
      end
    end
  end

  if_skid_buf #(.XLEN(XLEN)) u_skid (
    .clk        (clk),
    .rst        (rst),
    .load       (buf_load_s),
    .drain      (buf_drain_s),
    .flush      (redirect),
    .load_pc    (inflight_pc_r),
    .load_instr (imem_rdata),
    .buf_valid  (buf_valid_s),
    .buf_pc     (buf_pc_s),
    .buf_instr  (buf_instr_s)
  );

  assign imem_req  = req_s;
  assign imem_addr = rst ? RESET_PC : fetch_pc_r;
  assign id_valid  = id_r.valid;
  assign id_pc     = id_r.pc;
  assign id_instr  = id_r.instr;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: streaming, stall/skid, redirects,
// mid-run reset and PC wrap, against a simple 1-cycle instruction memory.
module tb_if_fetch_stage;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk;
  logic        rst_a, stall_a, redirect_a;
  logic [31:0] redirect_pc_a, rdata_a, addr_a, id_pc_a, id_instr_a;
  logic        req_a, id_valid_a;
  logic        rst_b, stall_b, redirect_b;
  logic [31:0] redirect_pc_b, rdata_b, addr_b, id_pc_b, id_instr_b;
  logic        req_b, id_valid_b;

  int total = 0;
  int bad   = 0;

  if_fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut_a (
    .clk(clk), .rst(rst_a), .imem_req(req_a), .imem_addr(addr_a),
    .imem_rdata(rdata_a), .stall(stall_a), .redirect(redirect_a),
    .redirect_pc(redirect_pc_a), .id_valid(id_valid_a), .id_pc(id_pc_a),
    .id_instr(id_instr_a)
  );

  if_fetch_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8)) dut_b (
    .clk(clk), .rst(rst_b), .imem_req(req_b), .imem_addr(addr_b),
    .imem_rdata(rdata_b), .stall(stall_b), .redirect(redirect_b),
    .redirect_pc(redirect_pc_b), .id_valid(id_valid_b), .id_pc(id_pc_b),
    .id_instr(id_instr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: word = address ^ K, one cycle after the request.
  always @(posedge clk) begin
    rdata_a <= addr_a ^ K;
    rdata_b <= addr_b ^ K;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_id(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'd0, id_valid_a}, 32'd1);
    chk({tag, "_pc"}, id_pc_a, pc);
    chk({tag, "_instr"}, id_instr_a, pc ^ K);
  endtask

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] exp_b;
    rst_a = 1'b1; stall_a = 1'b0; redirect_a = 1'b0; redirect_pc_a = 32'd0;
    rst_b = 1'b1; stall_b = 1'b0; redirect_b = 1'b0; redirect_pc_b = 32'd0;
    tick(); tick();

    // Reset values.
    chk("rst_req", {31'd0, req_a}, 32'd0);
    chk("rst_addr", addr_a, 32'd0);
    chk("rst_addr_b", addr_b, 32'hFFFF_FFF8);
    chk("rst_valid", {31'd0, id_valid_a}, 32'd0);
    chk("rst_pc", id_pc_a, 32'd0);
    chk("rst_instr", id_instr_a, 32'd0);

    // Streaming and stall in cycles 5..7; cycle 0 follows.
    tick(); rst_a = 1'b0; rst_b = 1'b0; #1;
    chk("c0_req", {31'd0, req_a}, 32'd1);
    chk("c0_addr", addr_a, 32'd0);
    for (int c = 1; c <= 11; c++) begin
      tick();
      stall_a = (c >= 5 && c <= 7);
      #1;
      if (c >= 5 && c <= 7) begin
        chk("stall_req", {31'd0, req_a}, 32'd0);
      end else begin
        chk("run_req", {31'd0, req_a}, 32'd1);
        chk("run_addr", addr_a, (c <= 4) ? 32'(4 * c) : 32'(4 * (c - 3)));
      end
      if (c == 1) begin
        chk("c1_valid", {31'd0, id_valid_a}, 32'd0);
      end else begin
        exp_pc = (c <= 5) ? 32'(4 * (c - 2)) : (c <= 8) ? 32'd12 : 32'(16 + 4 * (c - 9));
        chk_id("stream", exp_pc);
      end
      if (c >= 2 && c <= 5) begin
        exp_b = 32'hFFFF_FFF8 + 32'(4 * (c - 2));
        chk("wrap_valid", {31'd0, id_valid_b}, 32'd1);
        chk("wrap_pc", id_pc_b, exp_b);
        chk("wrap_instr", id_instr_b, exp_b ^ K);
      end
    end

    // Redirect to 0x40 in cycle 6 of a fresh run.
    tick(); rst_a = 1'b1; #1;
    chk("rst2_req", {31'd0, req_a}, 32'd0);
    tick(); rst_a = 1'b0; #1;
    chk("r0_addr", addr_a, 32'd0);
    for (int c = 1; c <= 10; c++) begin
      tick();
      redirect_a = (c == 6);
      redirect_pc_a = 32'h0000_0040;
      #1;
      if (c >= 2 && c <= 6) chk_id("pre_redir", 32'(4 * (c - 2)));
      else if (c == 7 || c == 8) chk("bubble_valid", {31'd0, id_valid_a}, 32'd0);
      else if (c >= 9) chk_id("target", 32'(32'h40 + 4 * (c - 9)));
      else chk("r1_valid", {31'd0, id_valid_a}, 32'd0);
      if (c == 6) chk("redir_req", {31'd0, req_a}, 32'd0);
      if (c == 7) chk("target_addr", addr_a, 32'h0000_0040);
    end

    // Stall fills the buffer, then redirect to 0x100 while in BUF.
    tick(); stall_a = 1'b1; #1;
    chk_id("c11", 32'h48);
    tick(); redirect_a = 1'b1; redirect_pc_a = 32'h0000_0100; #1;
    chk_id("c12", 32'h48);
    chk("c12_req", {31'd0, req_a}, 32'd0);
    tick(); redirect_a = 1'b0; #1;
    chk("c13_valid", {31'd0, id_valid_a}, 32'd0);
    chk("c13_req", {31'd0, req_a}, 32'd0);
    tick(); stall_a = 1'b0; #1;
    chk("c14_valid", {31'd0, id_valid_a}, 32'd0);
    chk("c14_req", {31'd0, req_a}, 32'd1);
    chk("c14_addr", addr_a, 32'h0000_0100);
    tick(); #1;
    chk("c15_valid", {31'd0, id_valid_a}, 32'd0);
    tick(); #1;
    chk_id("c16", 32'h100);
    tick(); #1;
    chk_id("c17", 32'h104);

    // One-cycle reset while in BUF, then restart from RESET_PC.
    tick(); stall_a = 1'b1; #1;
    chk_id("c18", 32'h108);
    tick(); rst_a = 1'b1; #1;
    chk("c19_req", {31'd0, req_a}, 32'd0);
    tick(); rst_a = 1'b0; stall_a = 1'b0; #1;
    chk("post_rst_valid", {31'd0, id_valid_a}, 32'd0);
    chk("post_rst_pc", id_pc_a, 32'd0);
    chk("post_rst_instr", id_instr_a, 32'd0);
    chk("post_rst_req", {31'd0, req_a}, 32'd1);
    chk("post_rst_addr", addr_a, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      tick(); #1;
      if (k == 1) chk("restart_bubble", {31'd0, id_valid_a}, 32'd0);
      else chk_id("restart", 32'(4 * (k - 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
